// File: rtl/mul_operand_seq.sv
// mul_operand_seq
//   Operand sequencer for a digit-serial multiplier. On an accepted start it
//   captures operand A (held on a_o for the digit-transform array) and operand
//   B, then broadcasts B one 2-bit digit per cycle, most significant first.
//   A FLUSH cycle lets the transform array drain, then a one-cycle done pulse
//   closes the sequence.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      load operands and begin a sequence (accepted in IDLE only)
//   abort      synchronous cancel of a running sequence
//   hold       downstream stall, freezes digit issue
//   a_in/b_in  operands, digit k at bits [2k+1:2k]
//   ready      high in IDLE
//   a_o        captured A, stable for the whole sequence
//   b_o        current B digit
//   digit_idx  index of the digit on b_o
//   digit_vld  b_o/digit_idx carry a newly issued digit
//   last       issued digit is digit 0
//   m_vld      transform-array output valid (digit_vld delayed one cycle)
//   m_last     last delayed one cycle
//   done       one-cycle completion pulse
//   err        sticky flag: a captured operand held the illegal code 2'b11
module mul_operand_seq #(
    parameter int P  = 33,
    parameter int IW = $clog2(P)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            hold,
    input  logic [2*P-1:0]  a_in,
    input  logic [2*P-1:0]  b_in,
    output logic            ready,
    output logic [2*P-1:0]  a_o,
    output logic [1:0]      b_o,
    output logic [IW-1:0]   digit_idx,
    output logic            digit_vld,
    output logic            last,
    output logic            m_vld,
    output logic            m_last,
    output logic            done,
    output logic            err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [2*P-1:0]  r_a;
    logic [2*P-1:0]  r_bsh;      // digits of B not yet loaded onto b_o, MSB-aligned
    logic [1:0]      r_b;
    logic [IW-1:0]   r_idx;
    logic            r_vld;
    logic            r_last;
    logic            r_mvld;
    logic            r_mlast;
    logic            r_done;
    logic            r_err;

    state_t          w_state_nxt;
    logic [2*P-1:0]  w_a_nxt;
    logic [2*P-1:0]  w_bsh_nxt;
    logic [1:0]      w_b_nxt;
    logic [IW-1:0]   w_idx_nxt;
    logic            w_vld_nxt;
    logic            w_last_nxt;
    logic            w_mvld_nxt;
    logic            w_mlast_nxt;
    logic            w_done_nxt;
    logic            w_err_nxt;
    logic            w_illegal;

    localparam logic [IW-1:0] TOP_IDX = IW'(P - 1);

    // Any 2'b11 digit in either incoming operand.
    always_comb begin
        w_illegal = 1'b0;
        for (int unsigned k = 0; k < P; k++) begin
            if (a_in[2*k +: 2] == 2'b11 || b_in[2*k +: 2] == 2'b11) begin
                w_illegal = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_bsh_nxt   = r_bsh;
        w_b_nxt     = r_b;
        w_idx_nxt   = r_idx;
        w_vld_nxt   = 1'b0;
        w_mvld_nxt  = r_vld;
        w_mlast_nxt = r_last;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_a_nxt     = a_in;
                    w_b_nxt     = b_in[2*P-1 -: 2];
                    w_bsh_nxt   = b_in << 2;
                    w_idx_nxt   = TOP_IDX;
                    w_vld_nxt   = 1'b1;
                    w_err_nxt   = w_illegal;
                end
            end
            // b_o always shows the next digit to be issued; digit_vld marks
            // the cycle it is actually issued. A stall that begins right after
            // an issue still advances b_o to the following digit, but leaves
            // it unissued until hold drops, so each digit is valid exactly once.
            S_RUN: begin
                if (r_vld) begin
                    if (r_idx == '0) begin
                        w_state_nxt = S_FLUSH;
                        w_b_nxt     = '0;
                    end else begin
                        w_b_nxt   = r_bsh[2*P-1 -: 2];
                        w_bsh_nxt = r_bsh << 2;
                        w_idx_nxt = r_idx - IW'(1);
                        w_vld_nxt = !hold;
                    end
                end else begin
                    w_vld_nxt = !hold;
                end
            end
            S_FLUSH: begin
                w_state_nxt = S_DONE;
                w_b_nxt     = '0;
                w_done_nxt  = 1'b1;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort outranks hold and every in-sequence transition; A is kept.
        if (abort && r_state != S_IDLE) begin
            w_state_nxt = S_IDLE;
            w_b_nxt     = '0;
            w_idx_nxt   = '0;
            w_vld_nxt   = 1'b0;
            w_mvld_nxt  = 1'b0;
            w_mlast_nxt = 1'b0;
            w_done_nxt  = 1'b0;
        end

        w_last_nxt = w_vld_nxt && (w_idx_nxt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_bsh   <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_vld   <= 1'b0;
            r_last  <= 1'b0;
            r_mvld  <= 1'b0;
            r_mlast <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_bsh   <= w_bsh_nxt;
            r_b     <= w_b_nxt;
            r_idx   <= w_idx_nxt;
            r_vld   <= w_vld_nxt;
            r_last  <= w_last_nxt;
            r_mvld  <= w_mvld_nxt;
            r_mlast <= w_mlast_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign ready     = (r_state == S_IDLE);
    assign a_o       = r_a;
    assign b_o       = r_b;
    assign digit_idx = r_idx;
    assign digit_vld = r_vld;
    assign last      = r_last;
    assign m_vld     = r_mvld;
    assign m_last    = r_mlast;
    assign done      = r_done;
    assign err       = r_err;

    a_idx_range: assert property (@(posedge clk) disable iff (!rst_n)
        digit_idx <= TOP_IDX);
    a_last_vld: assert property (@(posedge clk) disable iff (!rst_n)
        last |-> digit_vld);
    a_done_idle: assert property (@(posedge clk) disable iff (!rst_n)
        done |=> ready);

endmodule
